pe_scanline_reader: RTL and testbench



---
 rtl/pe_pkg.sv | 14 +
 rtl/pe_line_ram.sv | 33 +++
 rtl/pe_scanline_reader.sv | 191 +++++++++++++++++++
 tb/tb_pe_scanline_reader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-evaluation scanline path.
package pe_pkg;

    localparam int unsigned LINE_W_GBA = 240;

    typedef logic [14:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/pe_line_ram.sv
// Two-bank simple dual-port line RAM: one write port, one read port, 1-cycle read latency.
module pe_line_ram #(
    parameter int unsigned LINE_W  = 240,
    parameter int unsigned COLOR_W = 15
) (
    input  logic                      clock,
    input  logic                      wr_en_i,
    input  logic                      wr_bank_i,
    input  logic [$clog2(LINE_W)-1:0] wr_col_i,
    input  logic [COLOR_W-1:0]        wr_data_i,
    input  logic                      rd_en_i,
    input  logic                      rd_bank_i,
    input  logic [$clog2(LINE_W)-1:0] rd_col_i,
    output logic [COLOR_W-1:0]        rd_data_o
);

    logic [COLOR_W-1:0] mem_q [2][LINE_W];

    // Write port: store the accepted pixel.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_col_i] <= wr_data_i;
        end
    end

    // Read port: registered output, data valid the cycle after rd_en_i.
    always_ff @(posedge clock) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_bank_i][rd_col_i];
        end
    end

endmodule

// File: rtl/pe_scanline_reader.sv
// Ping-pong scanline buffer: writer fills one bank while the reader streams the other
// out as a valid/ready pixel stream through a 2-entry skid buffer.
module pe_scanline_reader
    import pe_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_GBA,
    parameter int unsigned COLOR_W = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wr_valid,
    input  logic [COLOR_W-1:0] wr_pixel,
    output logic               wr_ready,
    input  logic               wr_abort,
    output logic               out_valid,
    output logic [COLOR_W-1:0] out_pixel,
    output logic               out_last,
    input  logic               out_ready,
    output logic [1:0]         bank_full
);

    localparam int unsigned   CW       = $clog2(LINE_W);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

    // Write side
    logic [CW-1:0] wcol_q, wcol_d;
    logic          wbank_q, wbank_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    full_set, full_clr;
    logic          wr_accept;

    // Read side
    rd_state_t          state_q, state_d;
    logic [CW-1:0]      rcol_q, rcol_d;
    logic               rbank_q, rbank_d;
    logic               issued_q, issued_d;
    logic               pend_q, pend_d;
    logic               pend_last_q, pend_last_d;
    logic [COLOR_W-1:0] skid_pix_q [2];
    logic [COLOR_W-1:0] skid_pix_d [2];
    logic [1:0]         skid_last_q, skid_last_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         occ, remain;
    logic               rd_issue, pop, pop_last;
    logic [COLOR_W-1:0] rd_data;

    assign wr_ready  = !full_q[wbank_q];
    assign wr_accept = wr_valid && wr_ready && !wr_abort;
    assign bank_full = full_q;

    assign out_valid = (cnt_q != 2'd0);
    assign out_pixel = skid_pix_q[0];
    assign out_last  = out_valid && skid_last_q[0];
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && skid_last_q[0];

    // Skid occupancy after this cycle's landing read and pop; a new read may issue
    // only if its data will still find a free slot when it lands.
    assign occ    = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    assign remain = cnt_q - {1'b0, pop};

    assign full_set = (wr_accept && (wcol_q == COL_LAST)) ? (2'b01 << wbank_q) : 2'b00;
    assign full_clr = pop_last ? (2'b01 << rbank_q) : 2'b00;

    // Write pointer and bank flags; abort rewinds the column and wins over a write.
    always_comb begin
        wcol_d  = wcol_q;
        wbank_d = wbank_q;
        full_d  = (full_q | full_set) & ~full_clr;
        if (wr_abort) begin
            wcol_d = '0;
        end else if (wr_accept) begin
            if (wcol_q == COL_LAST) begin
                wcol_d  = '0;
                wbank_d = ~wbank_q;
            end else begin
                wcol_d = wcol_q + CW'(1);
            end
        end
    end

    // Reader FSM: decides when a RAM read is issued and when a line is finished.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_issue = 1'b1;
                    state_d  = PRIME;
                end
            end
            PRIME: begin
                rd_issue = !issued_q && (occ <= 2'd1);
                if (pend_q) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd_issue = !issued_q && (occ <= 2'd1);
                if (pop_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read pointer, in-flight read tracking and bank release on the last pop.
    always_comb begin
        rcol_d      = rcol_q;
        rbank_d     = rbank_q;
        issued_d    = issued_q;
        pend_d      = rd_issue;
        pend_last_d = rd_issue && (rcol_q == COL_LAST);
        if (rd_issue) begin
            if (rcol_q == COL_LAST) begin
                issued_d = 1'b1;
            end else begin
                rcol_d = rcol_q + CW'(1);
            end
        end
        if (pop_last) begin
            rcol_d   = '0;
            issued_d = 1'b0;
            rbank_d  = ~rbank_q;
        end
    end

    // Skid buffer: head shifts out on pop, landing RAM data fills the next free slot.
    always_comb begin
        skid_pix_d  = skid_pix_q;
        skid_last_d = skid_last_q;
        cnt_d       = occ;
        if (pop) begin
            skid_pix_d[0]  = skid_pix_q[1];
            skid_last_d[0] = skid_last_q[1];
        end
        if (pend_q) begin
            skid_pix_d[|remain]  = rd_data;
            skid_last_d[|remain] = pend_last_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcol_q      <= '0;
            wbank_q     <= 1'b0;
            full_q      <= '0;
            state_q     <= IDLE;
            rcol_q      <= '0;
            rbank_q     <= 1'b0;
            issued_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            skid_pix_q  <= '{default: '0};
            skid_last_q <= '0;
            cnt_q       <= '0;
        end else begin
            wcol_q      <= wcol_d;
            wbank_q     <= wbank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rcol_q      <= rcol_d;
            rbank_q     <= rbank_d;
            issued_q    <= issued_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            skid_pix_q  <= skid_pix_d;
            skid_last_q <= skid_last_d;
            cnt_q       <= cnt_d;
        end
    end

    pe_line_ram #(
        .LINE_W  (LINE_W),
        .COLOR_W (COLOR_W)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_accept),
        .wr_bank_i (wbank_q),
        .wr_col_i  (wcol_q),
        .wr_data_i (wr_pixel),
        .rd_en_i   (rd_issue),
        .rd_bank_i (rbank_q),
        .rd_col_i  (rcol_q),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_pe_scanline_reader.sv
// Directed bench for the ping-pong scanline reader.
module tb_pe_scanline_reader;

    localparam int LW = 240;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b1;
    logic        wr_valid  = 1'b0;
    logic [14:0] wr_pixel  = '0;
    logic        wr_abort  = 1'b0;
    logic        out_ready = 1'b0;
    logic        wr_ready;
    logic        out_valid;
    logic [14:0] out_pixel;
    logic        out_last;
    logic [1:0]  bank_full;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pe_scanline_reader #(
        .LINE_W  (LW),
        .COLOR_W (15)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_pixel  (wr_pixel),
        .wr_ready  (wr_ready),
        .wr_abort  (wr_abort),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .out_ready (out_ready),
        .bank_full (bank_full)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        wr_valid  = 1'b0;
        wr_abort  = 1'b0;
        out_ready = 1'b0;
        wr_pixel  = '0;
        reset_n   = 1'b0;
        tick();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_line(input logic [14:0] base);
        for (int i = 0; i < LW; i++) begin
            wr_valid = 1'b1;
            wr_pixel = base + 15'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, out_pixel, bank_full} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_during: got v=%b l=%b p=%h full=%b, want all zero",
                     out_valid, out_last, out_pixel, bank_full);
        end
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, bank_full, wr_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_release: got v=%b full=%b wr_ready=%b, want v=0 full=00 wr_ready=1",
                     out_valid, bank_full, wr_ready);
        end
    endtask

    task automatic test_single_line();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < LW; i++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'(i);
            if (i == 0 || i == LW - 1) begin
                n_cmp++;
                if (wr_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL t1_wr_ready col %0d: got %b want 1", i, wr_ready);
                end
            end
            tick();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b010) begin
            n_bad++;
            $display("FAIL t1_full: got full=%b v=%b, want full=01 v=0", bank_full, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_latency1: got v=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_latency2: got v=%b want 1", out_valid);
        end
        for (int i = 0; i < LW; i++) begin
            n_cmp++;
            if ({out_valid, out_last, out_pixel} !== {1'b1, (i == LW - 1), 15'(i)}) begin
                n_bad++;
                $display("FAIL t1_pix[%0d]: got v=%b l=%b p=%h, want v=1 l=%b p=%h",
                         i, out_valid, out_last, out_pixel, (i == LW - 1), 15'(i));
            end
            tick();
        end
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t1_release: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
    endtask

    task automatic test_two_lines_stall();
        int k, cyc, gap;
        logic [14:0] exp_p;
        logic        exp_l;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * LW; i++) begin
            wr_valid = 1'b1;
            wr_pixel = (i < LW) ? 15'h1000 + 15'(i) : 15'h2000 + 15'(i - LW);
            tick();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if ({bank_full, wr_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL t2_both_full: got full=%b wr_ready=%b, want 11 0", bank_full, wr_ready);
        end
        wr_valid = 1'b1;
        wr_pixel = 15'h7ABC;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({bank_full, wr_ready, out_valid, out_last, out_pixel} !== {2'b11, 1'b0, 1'b1, 1'b0, 15'h1000}) begin
            n_bad++;
            $display("FAIL t2_stalled: got full=%b wr_ready=%b v=%b l=%b p=%h, want 11 0 1 0 1000",
                     bank_full, wr_ready, out_valid, out_last, out_pixel);
        end
        wr_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0; cyc = 0; gap = 0;
        while (k < 2 * LW && cyc < 2000) begin
            if (out_valid) begin
                exp_p = (k < LW) ? 15'h1000 + 15'(k) : 15'h2000 + 15'(k - LW);
                exp_l = (k == LW - 1) || (k == 2 * LW - 1);
                n_cmp++;
                if ({out_last, out_pixel} !== {exp_l, exp_p}) begin
                    n_bad++;
                    $display("FAIL t2_pix[%0d]: got l=%b p=%h, want l=%b p=%h",
                             k, out_last, out_pixel, exp_l, exp_p);
                end
                k++;
            end else if (k == LW) begin
                gap++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (k != 2 * LW) begin
            n_bad++;
            $display("FAIL t2_count: got %0d pixels, want %0d", k, 2 * LW);
        end
        n_cmp++;
        if (gap > 2) begin
            n_bad++;
            $display("FAIL t2_gap: got %0d idle cycles, want at most 2", gap);
        end
        tick();
        tick();
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t2_drained: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int k, cyc;
        logic        prev_stall;
        logic [16:0] cur, prev;
        do_reset();
        write_line(15'h3000);
        k = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
        while (k < LW && cyc < 3000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            cur = {out_valid, out_last, out_pixel};
            if (prev_stall) begin
                n_cmp++;
                if (cur !== prev) begin
                    n_bad++;
                    $display("FAIL t3_hold: got %h, want held %h", cur, prev);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if ({out_last, out_pixel} !== {(k == LW - 1), 15'h3000 + 15'(k)}) begin
                    n_bad++;
                    $display("FAIL t3_pix[%0d]: got l=%b p=%h, want l=%b p=%h",
                             k, out_last, out_pixel, (k == LW - 1), 15'h3000 + 15'(k));
                end
                k++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (k != LW) begin
            n_bad++;
            $display("FAIL t3_count: got %0d pixels, want %0d", k, LW);
        end
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t3_release: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
    endtask

    task automatic test_abort();
        int k, cyc;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'h0500 + 15'(i);
            tick();
        end
        wr_abort = 1'b1;
        wr_valid = 1'b1;
        wr_pixel = 15'h7FFF;
        tick();
        wr_abort = 1'b0;
        wr_valid = 1'b0;
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t4_after_abort: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
        write_line(15'h0100);
        n_cmp++;
        if (bank_full !== 2'b01) begin
            n_bad++;
            $display("FAIL t4_full: got full=%b, want 01", bank_full);
        end
        k = 0; cyc = 0;
        while (k < LW && cyc < 1000) begin
            if (out_valid) begin
                n_cmp++;
                if ({out_last, out_pixel} !== {(k == LW - 1), 15'h0100 + 15'(k)}) begin
                    n_bad++;
                    $display("FAIL t4_pix[%0d]: got l=%b p=%h, want l=%b p=%h",
                             k, out_last, out_pixel, (k == LW - 1), 15'h0100 + 15'(k));
                end
                k++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (k != LW) begin
            n_bad++;
            $display("FAIL t4_count: got %0d pixels, want %0d", k, LW);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t4_no_extra_line: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int k, cyc;
        do_reset();
        out_ready = 1'b1;
        write_line(15'h4000);
        k = 0; cyc = 0;
        while (k < 57 && cyc < 1000) begin
            if (out_valid) k++;
            tick();
            cyc++;
        end
        n_cmp++;
        if ({out_valid, out_pixel} !== {1'b1, 15'h4039}) begin
            n_bad++;
            $display("FAIL t5_col57: got v=%b p=%h after %0d pops, want v=1 p=4039", out_valid, out_pixel, k);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, bank_full} !== 4'b0000) begin
            n_bad++;
            $display("FAIL t5_async_reset: got v=%b l=%b full=%b, want 0 0 00", out_valid, out_last, bank_full);
        end
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({bank_full, out_valid, wr_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL t5_release: got full=%b v=%b wr_ready=%b, want 00 0 1", bank_full, out_valid, wr_ready);
        end
        write_line(15'h4400);
        tick();
        tick();
        for (int i = 0; i < LW; i++) begin
            n_cmp++;
            if ({out_valid, out_last, out_pixel} !== {1'b1, (i == LW - 1), 15'h4400 + 15'(i)}) begin
                n_bad++;
                $display("FAIL t5_pix[%0d]: got v=%b l=%b p=%h, want v=1 l=%b p=%h",
                         i, out_valid, out_last, out_pixel, (i == LW - 1), 15'h4400 + 15'(i));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        write_line(15'h5000);
        tick();
        tick();
        for (int j = 0; j < LW; j++) begin
            wr_valid = 1'b1;
            wr_pixel = 15'h6000 + 15'(j);
            n_cmp++;
            if ({out_valid, out_last, out_pixel} !== {1'b1, (j == LW - 1), 15'h5000 + 15'(j)}) begin
                n_bad++;
                $display("FAIL t6_line1[%0d]: got v=%b l=%b p=%h, want v=1 l=%b p=%h",
                         j, out_valid, out_last, out_pixel, (j == LW - 1), 15'h5000 + 15'(j));
            end
            if (j == LW - 1) begin
                n_cmp++;
                if (bank_full !== 2'b01) begin
                    n_bad++;
                    $display("FAIL t6_before: got full=%b, want 01", bank_full);
                end
            end
            tick();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL t6_swap: got full=%b v=%b, want 10 0", bank_full, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL t6_gap: got v=%b, want 0", out_valid);
        end
        tick();
        for (int i = 0; i < LW; i++) begin
            n_cmp++;
            if ({out_valid, out_last, out_pixel} !== {1'b1, (i == LW - 1), 15'h6000 + 15'(i)}) begin
                n_bad++;
                $display("FAIL t6_line2[%0d]: got v=%b l=%b p=%h, want v=1 l=%b p=%h",
                         i, out_valid, out_last, out_pixel, (i == LW - 1), 15'h6000 + 15'(i));
            end
            tick();
        end
        n_cmp++;
        if ({bank_full, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL t6_release: got full=%b v=%b, want 00 0", bank_full, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_two_lines_stall();
        test_backpressure();
        test_abort();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
